adc_spi_resp: RTL and testbench
===============================

ADC_SPI_RESP -- requirements
Module: adc_spi_resp

Interface
REQ-001 clk  input  1  system clock; all logic on its rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 SS_n  input  1  SPI slave select from the A2D master, active-low, asynchronous to clk.
REQ-004 SCLK  input  1  SPI clock from the master, idles high, asynchronous to clk.
REQ-005 MOSI  input  1  command bit from the master, sampled on SCLK rise.
REQ-006 MISO  output  1  response bit to the master, changes on SCLK fall.
REQ-007 rd_req  output  1  one-clock pulse requesting a sample for rd_chnnl.
REQ-008 rd_chnnl  output  3  channel captured from the last complete frame.
REQ-009 rd_data  input  12  sample returned by the data source.
REQ-010 rd_vld  input  1  rd_data valid strobe, one clock.
REQ-011 conv_cnt  output  8  count of complete frames, wraps 255->0.
REQ-012 frame_err  output  1  one-clock pulse on an aborted frame.

Function
REQ-013 SS_n, SCLK and MOSI SHALL each pass through a 2-flop synchronizer; a third SCLK/SS_n flop SHALL feed edge detectors, and all edge behaviour below refers to these synchronized signals.
REQ-014 FSM states SHALL be IDLE, SHIFT and WAIT_DATA.
REQ-015 IDLE->SHIFT on the SS_n fall: load tx_shft = {4'h0, resp_reg}, clear bit counter, drive MISO = tx_shft[15].
REQ-016 In SHIFT each SCLK rise SHALL shift MOSI into rx_shft[15:0] MSB-first and increment a 5-bit bit counter.
REQ-017 In SHIFT each SCLK fall after the first rise SHALL left-shift tx_shft; the SCLK fall before the first rise SHALL NOT shift.
REQ-018 An SS_n rise with bit counter == 16 SHALL complete the frame: rd_chnnl <= rx_shft[13:11], rd_req pulses the next cycle, conv_cnt increments, and the FSM goes to WAIT_DATA.
REQ-019 An SS_n rise with bit counter != 16 SHALL abort the frame: pulse frame_err, leave rd_chnnl, conv_cnt and resp_reg unchanged, and return to IDLE.
REQ-020 SCLK rises beyond 16 within one frame SHALL be ignored; the counter saturates at 16 and the frame still completes.
REQ-021 WAIT_DATA->IDLE on rd_vld: resp_reg <= rd_data, transformed per REQ-027.
REQ-022 An SS_n fall while in WAIT_DATA SHALL drop the pending request, set resp_reg = 12'hFFF, and enter SHIFT with that value loaded.
REQ-023 rd_vld asserted outside WAIT_DATA SHALL be ignored.
REQ-024 Frame N's command selects the data returned in frame N+1; the first frame after reset returns 12'h000 (pre-transform).
REQ-025 MISO SHALL be 0 whenever the FSM is not in SHIFT.

Reset
REQ-026 With rst_n low at a clk rise: FSM = IDLE; MISO, rd_req and frame_err = 0; rd_chnnl = 3'h0; conv_cnt = 8'h00; resp_reg = 12'h000; shift registers, counter and synchronizer flops cleared, with the SS_n/SCLK synchronizer flops set to 1. Reset mid-frame abandons the frame with no frame_err pulse.

Configuration
REQ-027 Macro ADC_RESP_INVERT_EN: when defined, resp_reg is loaded with ~rd_data (the master's result is the complement of the sample) and the REQ-022 value becomes 12'h000; when undefined, resp_reg = rd_data and the REQ-022 value is 12'hFFF.

Verification
REQ-028 After reset, frame 1 with MOSI word 16'h1800 -> MISO returns 16'h0000 (or 16'h0FFF with the macro), rd_req pulses once with rd_chnnl = 3, and conv_cnt = 1.
REQ-029 Frame 1 followed by rd_vld with rd_data = 12'hA5C, then frame 2 -> MISO returns 16'h0A5C (16'h05A3 with the macro), conv_cnt = 2.
REQ-030 Sweep chnnl 0..7, 2 frames each -> every captured rd_chnnl matches, conv_cnt = 16; continuing to 256 complete frames wraps conv_cnt to 0.
REQ-031 SS_n rises after 9 SCLK rises -> frame_err pulses once, no rd_req, conv_cnt and rd_chnnl unchanged, next full frame proceeds normally.
REQ-032 SS_n falls while in WAIT_DATA (rd_vld withheld) -> frame returns 16'h0FFF (16'h0000 with the macro); a late rd_vld is ignored.
REQ-033 rst_n low mid-frame after 8 SCLK rises -> all outputs at reset values, no frame_err, next frame behaves as the first after reset.

Source files
------------

// File: rtl/adc_spi_resp.sv
// adc_spi_resp -- SPI slave that emulates an A2D converter front end.
//
// The master sends a 16-bit command while the slave returns the 12-bit
// response captured from the previous frame, right-justified in 16 bits.
// The command's bits [13:11] select the channel. A complete frame latches
// the channel and raises a one-clock sample request. The next sample
// returned by the data source becomes the response for the following frame.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   SS_n       SPI slave select (active-low, asynchronous to clk)
//   SCLK       SPI clock (idles high, asynchronous to clk)
//   MOSI       command bit, sampled on SCLK rise
//   MISO       response bit, updated on SCLK fall, 0 outside SHIFT
//   rd_req     one-clock sample request for rd_chnnl
//   rd_chnnl   channel from the last complete frame
//   rd_data    sample from the data source
//   rd_vld     rd_data valid strobe
//   conv_cnt   complete-frame counter, wraps 255->0
//   frame_err  one-clock pulse on an aborted frame
//
// Build option: define ADC_RESP_INVERT_EN to return the complement of the
// sample. The WAIT_DATA overrun fill value then becomes 12'h000.
module adc_spi_resp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        rd_req,
  output logic [2:0]  rd_chnnl,
  input  logic [11:0] rd_data,
  input  logic        rd_vld,
  output logic [7:0]  conv_cnt,
  output logic        frame_err
);

`ifdef ADC_RESP_INVERT_EN
  localparam logic [11:0] FILL_VAL = 12'h000;
  // The reset sample is treated as 0, then complemented like any other sample.
  localparam logic [11:0] RESP_RST = 12'hFFF;
  function automatic logic [11:0] xform(input logic [11:0] d);
    return ~d;
  endfunction
`else
  localparam logic [11:0] FILL_VAL = 12'hFFF;
  localparam logic [11:0] RESP_RST = 12'h000;
  function automatic logic [11:0] xform(input logic [11:0] d);
    return d;
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_DATA} state_t;

  state_t      state;
  logic [2:0]  ss_sync, sclk_sync;
  logic [1:0]  mosi_sync;
  logic [15:0] tx_shft, rx_shft;
  logic [4:0]  bit_cnt;
  logic        seen_rise;
  logic [11:0] resp_reg;

  logic ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;
  logic [15:0] tx_load;

  // Index 1 is the synchronized level. Index 2 is the delayed copy used for
  // edge detection.
  assign ss_fall   =  ss_sync[2]   & ~ss_sync[1];
  assign ss_rise   = ~ss_sync[2]   &  ss_sync[1];
  assign sclk_fall =  sclk_sync[2] & ~sclk_sync[1];
  assign sclk_rise = ~sclk_sync[2] &  sclk_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign tx_load   = {4'h0, resp_reg};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ss_sync   <= '1;
      sclk_sync <= '1;
      mosi_sync <= '0;
      tx_shft   <= '0;
      rx_shft   <= '0;
      bit_cnt   <= '0;
      seen_rise <= 1'b0;
      resp_reg  <= RESP_RST;
      MISO      <= 1'b0;
      rd_req    <= 1'b0;
      rd_chnnl  <= '0;
      conv_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[1:0], SS_n};
      sclk_sync <= {sclk_sync[1:0], SCLK};
      mosi_sync <= {mosi_sync[0], MOSI};
      rd_req    <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          MISO <= 1'b0;
          if (ss_fall) begin
            tx_shft   <= tx_load;
            bit_cnt   <= '0;
            seen_rise <= 1'b0;
            MISO      <= tx_load[15];
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (ss_rise) begin
            MISO <= 1'b0;
            if (bit_cnt == 5'd16) begin
              rd_chnnl <= rx_shft[13:11];
              rd_req   <= 1'b1;
              conv_cnt <= conv_cnt + 8'd1;
              state    <= WAIT_DATA;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            if (sclk_rise) begin
              seen_rise <= 1'b1;
              // Rises past the 16th bit are dropped so the frame still completes.
              if (bit_cnt != 5'd16) begin
                rx_shft <= {rx_shft[14:0], mosi_s};
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
            // The fall that precedes the first rise leaves bit 15 on MISO.
            if (sclk_fall && seen_rise) begin
              tx_shft <= {tx_shft[14:0], 1'b0};
              MISO    <= tx_shft[14];
            end
          end
        end

        WAIT_DATA: begin
          MISO <= 1'b0;
          if (ss_fall) begin
            // The master started the next frame before the sample arrived.
            resp_reg  <= FILL_VAL;
            tx_shft   <= {4'h0, FILL_VAL};
            bit_cnt   <= '0;
            seen_rise <= 1'b0;
            MISO      <= 1'b0;
            state     <= SHIFT;
          end else if (rd_vld) begin
            resp_reg <= xform(rd_data);
            state    <= IDLE;
          end
        end

        default: begin
          MISO  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_resp.sv
// tb_adc_spi_resp -- directed self-checking bench for adc_spi_resp.
// Acts as the SPI master and the data source. Each expected response is
// derived from the sample handed over after the previous complete frame.
module tb_adc_spi_resp;

  logic        clk = 1'b0;
  logic        rst_n, SS_n, SCLK, MOSI, rd_vld;
  logic [11:0] rd_data;
  logic        MISO, rd_req, frame_err;
  logic [2:0]  rd_chnnl;
  logic [7:0]  conv_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int req_cnt = 0;
  int err_cnt = 0;

  localparam int unsigned HALF = 5;

`ifdef ADC_RESP_INVERT_EN
  localparam logic [11:0] FILL_EXP = 12'h000;
`else
  localparam logic [11:0] FILL_EXP = 12'hFFF;
`endif

  adc_spi_resp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .rd_req    (rd_req),
    .rd_chnnl  (rd_chnnl),
    .rd_data   (rd_data),
    .rd_vld    (rd_vld),
    .conv_cnt  (conv_cnt),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_req === 1'b1)    req_cnt <= req_cnt + 1;
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  function automatic logic [11:0] xf(input logic [11:0] d);
`ifdef ADC_RESP_INVERT_EN
    return ~d;
`else
    return d;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic give_data(input logic [11:0] d);
    rd_data = d;
    rd_vld  = 1'b1;
    wait_clk(1);
    rd_vld  = 1'b0;
    wait_clk(3);
  endtask

  // One master frame: nrise SCLK pulses, MISO captured just before each rise.
  task automatic spi_frame(input logic [15:0] w, input int unsigned nrise,
                           input bit keep_ss, input bit vld_mid,
                           output logic [15:0] r);
    r    = '0;
    SS_n = 1'b0;
    wait_clk(HALF);
    for (int unsigned i = 0; i < nrise; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? w[15 - i] : 1'b0;
      wait_clk(HALF);
      if (i < 16) r = {r[14:0], MISO};
      SCLK = 1'b1;
      wait_clk(HALF);
      if (vld_mid && i == 4) begin
        rd_data = 12'h3C3;
        rd_vld  = 1'b1;
        wait_clk(1);
        rd_vld  = 1'b0;
      end
    end
    if (!keep_ss) begin
      SS_n = 1'b1;
      wait_clk(2 * HALF);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},  32'(MISO),      32'h0);
    check({tag, "_req"},   32'(rd_req),    32'h0);
    check({tag, "_err"},   32'(frame_err), 32'h0);
    check({tag, "_chnl"},  32'(rd_chnnl),  32'h0);
    check({tag, "_conv"},  32'(conv_cnt),  32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    SS_n  = 1'b1;
    SCLK  = 1'b1;
    MOSI  = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
  endtask

  logic [15:0] r;
  logic [11:0] prev, d;
  int          base_req, base_err;

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    rd_vld = 1'b0; rd_data = '0;
    wait_clk(4);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    wait_clk(4);

    // First frame after reset, then a frame returning a supplied sample.
    base_req = req_cnt;
    spi_frame(16'h1800, 16, 0, 0, r);
    check("f1_miso", 32'(r), {20'h0, xf(12'h000)});
    check("f1_req",  32'(req_cnt - base_req), 32'd1);
    check("f1_chnl", 32'(rd_chnnl), 32'd3);
    check("f1_conv", 32'(conv_cnt), 32'd1);
    give_data(12'hA5C);
    spi_frame(16'h2000, 16, 0, 0, r);
    check("f2_miso", 32'(r), {20'h0, xf(12'hA5C)});
    check("f2_conv", 32'(conv_cnt), 32'd2);
    check("f2_chnl", 32'(rd_chnnl), 32'd4);

    // Channel sweep from reset, then run on to 256 frames.
    do_reset();
    base_req = req_cnt;
    prev = xf(12'h000);
    for (int unsigned k = 0; k < 16; k++) begin
      spi_frame(16'(k / 2) << 11, 16, 0, 0, r);
      check("sw_miso", 32'(r), {20'h0, prev});
      check("sw_chnl", 32'(rd_chnnl), k / 2);
      d = 12'h5A0 + 12'(k);
      give_data(d);
      prev = xf(d);
    end
    check("sw_conv", 32'(conv_cnt), 32'd16);
    check("sw_req",  32'(req_cnt - base_req), 32'd16);
    for (int unsigned k = 16; k < 256; k++) spi_frame(16'h1000, 16, 0, 0, r);
    check("wrap_conv", 32'(conv_cnt), 32'd0);
    check("wrap_chnl", 32'(rd_chnnl), 32'd2);

    // Aborted frame after 9 rises; rd_vld in IDLE is ignored.
    give_data(12'h7E1);
    base_req = req_cnt;
    base_err = err_cnt;
    spi_frame(16'h3800, 9, 0, 0, r);
    check("ab_err",  32'(err_cnt - base_err), 32'd1);
    check("ab_req",  32'(req_cnt - base_req), 32'd0);
    check("ab_conv", 32'(conv_cnt), 32'd0);
    check("ab_chnl", 32'(rd_chnnl), 32'd2);
    give_data(12'h123);
    spi_frame(16'h2800, 16, 0, 0, r);
    check("ab_next_miso", 32'(r), {20'h0, xf(12'h7E1)});
    check("ab_next_conv", 32'(conv_cnt), 32'd1);
    check("ab_next_chnl", 32'(rd_chnnl), 32'd5);
    check("ab_next_err",  32'(err_cnt - base_err), 32'd1);

    // Data withheld: fill value returned; rd_vld during SHIFT ignored.
    spi_frame(16'h0000, 16, 0, 1, r);
    check("fill_miso", 32'(r), {20'h0, FILL_EXP});
    spi_frame(16'h0800, 9, 0, 1, r);
    spi_frame(16'h0800, 16, 0, 0, r);
    check("fill2_miso", 32'(r), {20'h0, FILL_EXP});
    check("fill_conv",  32'(conv_cnt), 32'd3);
    check("fill_chnl",  32'(rd_chnnl), 32'd1);

    // Reset in the middle of a frame.
    base_err = err_cnt;
    spi_frame(16'h3800, 8, 1, 0, r);
    rst_n = 1'b0;
    wait_clk(2);
    check_reset_outputs("mid_rst");
    SS_n = 1'b1;
    SCLK = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(6);
    check("mid_rst_err", 32'(err_cnt - base_err), 32'd0);
    check("mid_rst_miso_idle", 32'(MISO), 32'h0);
    spi_frame(16'h1800, 16, 0, 0, r);
    check("post_rst_miso", 32'(r), {20'h0, xf(12'h000)});
    check("post_rst_conv", 32'(conv_cnt), 32'd1);
    check("post_rst_chnl", 32'(rd_chnnl), 32'd3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
